wb_timer: RTL and testbench



---
 rtl/wb_timer.sv | 151 +++++++++++++++
 tb/tb_wb_timer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic slave holding a RISC-V style 64-bit mtime/mtimecmp
// timer with a level interrupt. Every addressed cycle is acked after one wait state.
// Define WB_TIMER_PRESCALE_EN to build the prescale register and prescale counter;
// without it mtime advances on every enabled cycle and offset 0x10 reads as zero.
module wb_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        timer_int_o
);

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_CTRL     = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp;
    logic        en;
    logic        req;
    logic        wr;
    logic [2:0]  reg_sel;
    logic        tick;
    logic [31:0] rd_data;
    logic        unused_adr;

    // Byte-lane merge: lanes with their select bit set take the bus data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

    // A request is accepted only when no ack is outstanding, so a held strobe
    // during the ack cycle is not seen as a second access.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = req & wb_we_i;
    assign reg_sel = wb_adr_i[4:2];

    // Only adr[4:2] take part in decoding.
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

`ifdef WB_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    // Prescale register and divider counter; a prescale write restarts the divider.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr && (reg_sel == REG_PRESCALE)) begin
                prescale <= PRESCALE_W'(merge_bytes(32'(prescale), wb_dat_i, wb_sel_i));
                pre_cnt  <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end
        end
    end
`else
    logic [PRESCALE_W-1:0] unused_prescale;

    assign unused_prescale = '0;
    assign tick            = en;
`endif

    // Next mtime: a bus write to either half wins over the increment, and the
    // other half keeps its pre-edge value with no carry applied.
    always_comb begin
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        if (wr && (reg_sel == REG_MTIME_LO)) begin
            mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], wb_dat_i, wb_sel_i)};
        end else if (wr && (reg_sel == REG_MTIME_HI)) begin
            mtime_nxt = {merge_bytes(mtime[63:32], wb_dat_i, wb_sel_i), mtime[31:0]};
        end
    end

    // Timer state: mtime, compare value and enable bit.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b1;
        end else begin
            mtime <= mtime_nxt;
            if (wr && (reg_sel == REG_CMP_LO)) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wb_dat_i, wb_sel_i);
            end
            if (wr && (reg_sel == REG_CMP_HI)) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
            end
            if (wr && (reg_sel == REG_CTRL) && wb_sel_i[0]) begin
                en <= wb_dat_i[0];
            end
        end
    end

    // Read multiplexer on the pre-edge register values; unmapped offsets read 0.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_MTIME_LO: rd_data = mtime[31:0];
            REG_MTIME_HI: rd_data = mtime[63:32];
            REG_CMP_LO:   rd_data = mtimecmp[31:0];
            REG_CMP_HI:   rd_data = mtimecmp[63:32];
`ifdef WB_TIMER_PRESCALE_EN
            REG_PRESCALE: rd_data = 32'(prescale);
`endif
            REG_CTRL:     rd_data = {31'd0, en};
            default:      rd_data = '0;
        endcase
    end

    // Bus response and interrupt: ack pulse, registered read data, compare level.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            timer_int_o <= 1'b0;
        end else begin
            wb_ack_o    <= req;
            wb_dat_o    <= req ? rd_data : 32'd0;
            timer_int_o <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed and randomized bus accesses to wb_timer, compared against
// an arithmetic model of mtime (value anchored at a known edge plus elapsed edges
// divided by the prescale period). Works with or without WB_TIMER_PRESCALE_EN.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        tint;

    int cycles = 0;
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_val;
    int          m_cyc;
    int          m_phase;
    int          m_period;
    bit          m_en;
    logic [63:0] m_cmp;
    logic [63:0] m_cmp_prev;
    int          m_cmp_cyc;
`ifdef WB_TIMER_PRESCALE_EN
    localparam logic [31:0] PMASK = 32'((64'd1 << 16) - 64'd1);
    logic [31:0] m_pre;
`endif

    wb_timer #(.PRESCALE_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_dat_o   (dat_r),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_ack_o   (ack),
        .timer_int_o(tint)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycles <= cycles + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // mtime as it stands after clock edge number n
    function automatic logic [63:0] pred(input int n);
        longint total;
        if (!m_en) return m_val;
        total = longint'(m_phase) + longint'(n - m_cyc);
        return m_val + 64'(total / longint'(m_period));
    endfunction

    // prescale-divider phase after clock edge number n
    function automatic int pred_pc(input int n);
        if (!m_en) return m_phase;
        return int'((longint'(m_phase) + longint'(n - m_cyc)) % longint'(m_period));
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic exp_int(input int n);
        logic [63:0] c;
        c = ((n - 1) >= m_cmp_cyc) ? m_cmp : m_cmp_prev;
        return pred(n - 1) >= c;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int k);
        logic [63:0] t;
        logic [31:0] res;
        t   = pred(k - 1);
        res = 32'd0;
        case (a[4:2])
            3'd0: res = t[31:0];
            3'd1: res = t[63:32];
            3'd2: res = m_cmp[31:0];
            3'd3: res = m_cmp[63:32];
`ifdef WB_TIMER_PRESCALE_EN
            3'd4: res = m_pre;
`endif
            3'd5: res = {31'd0, m_en};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    task automatic model_reset();
        m_val      = 64'd0;
        m_cyc      = cycles;
        m_phase    = 0;
        m_period   = 1;
        m_en       = 1'b1;
        m_cmp      = '1;
        m_cmp_prev = '1;
        m_cmp_cyc  = 0;
`ifdef WB_TIMER_PRESCALE_EN
        m_pre      = 32'd0;
`endif
    endtask

    // Apply a write that committed at clock edge k
    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int k);
        logic [63:0] old;
        logic [63:0] now;
        int          pc;
        old = pred(k - 1);
        pc  = pred_pc(k - 1);
        case (a[4:2])
            3'd0: begin
                m_val   = {old[63:32], lanes(old[31:0], d, s)};
                m_phase = m_en ? ((pc + 1) % m_period) : pc;
                m_cyc   = k;
            end
            3'd1: begin
                m_val   = {lanes(old[63:32], d, s), old[31:0]};
                m_phase = m_en ? ((pc + 1) % m_period) : pc;
                m_cyc   = k;
            end
            3'd2: begin
                m_cmp_prev     = m_cmp;
                m_cmp[31:0]    = lanes(m_cmp[31:0], d, s);
                m_cmp_cyc      = k;
            end
            3'd3: begin
                m_cmp_prev     = m_cmp;
                m_cmp[63:32]   = lanes(m_cmp[63:32], d, s);
                m_cmp_cyc      = k;
            end
            3'd4: begin
`ifdef WB_TIMER_PRESCALE_EN
                now      = pred(k);
                m_pre    = lanes(m_pre, d, s) & PMASK;
                m_val    = now;
                m_cyc    = k;
                m_phase  = 0;
                m_period = int'(m_pre) + 1;
`endif
            end
            3'd5: begin
                if (s[0]) begin
                    now     = pred(k);
                    pc      = pred_pc(k);
                    m_val   = now;
                    m_phase = pc;
                    m_cyc   = k;
                    m_en    = d[0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; k is the edge that raised ack, ik the interrupt right after it
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit hold,
                       output logic [31:0] r, output int k, output logic ik);
        @(negedge clk);
        chk("ack_idle", ack, 0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        k  = cycles;
        r  = dat_r;
        ik = tint;
        chk("ack_rise", ack, 1);
        if (!hold) begin
            @(negedge clk);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
        @(posedge clk); #1;
        chk("ack_single", ack, 0);
        if (hold) begin
            @(negedge clk);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int k, output logic ik);
        logic [31:0] rr;
        bus(1'b1, a, d, s, 1'b0, rr, k, ik);
        chk("wr_int", ik, exp_int(k));
        model_write(a, d, s, k);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          output logic [31:0] r, output int k);
        logic ik;
        bus(1'b0, a, 32'd0, 4'hF, 1'b0, r, k, ik);
        chk(tag, r, exp_read(a, k));
        chk("rd_int", ik, exp_int(k));
    endtask

    logic [31:0] r, ra, rb, a, d;
    logic [3:0]  s;
    logic        ik;
    int          k, ka, kb, kp, km, n100, rise;

    initial begin
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat_w = 32'd0; sel = 4'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_r, 0);
        chk("rst_int", tint, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // reset register values
        rd_chk("cmp_lo_rst", 32'h08, r, k);
        chk("cmp_lo_ones", r, 32'hFFFF_FFFF);
        rd_chk("cmp_hi_rst", 32'h0C, r, k);
        chk("cmp_hi_ones", r, 32'hFFFF_FFFF);
        chk("int_low_rst", tint, 0);
        rd_chk("ctrl_rst", 32'h14, r, k);
        chk("ctrl_en", r, 32'h1);
        rd_chk("mtime_lo_rst", 32'h00, r, k);

        // byte-lane write and unmapped offsets
        wr(32'h08, 32'h0000_AB00, 4'b0010, k, ik);
        rd_chk("cmp_lo_byte", 32'h08, r, k);
        chk("cmp_lo_byte_val", r, 32'hFFFF_ABFF);
        wr(32'h18, 32'h1234_5678, 4'hF, k, ik);
        rd_chk("unmapped18", 32'h18, r, k);
        chk("unmapped18_zero", r, 32'd0);
        rd_chk("unmapped1c", 32'h1C, r, k);
        chk("unmapped1c_zero", r, 32'd0);

        // strobe held through the ack cycle is acked once
        bus(1'b0, 32'h14, 32'd0, 4'hF, 1'b1, r, k, ik);
        chk("held_rd", r, 32'h1);

        // mtime low write followed by an immediate read
        wr(32'h00, 32'd5, 4'hF, k, ik);
        rd_chk("mtime_after_wr", 32'h00, r, k);
        chk("mtime_range", (r >= 32'd6) && (r <= 32'd8), 1);

        // 64-bit wrap after exactly two enabled increments
        wr(32'h14, 32'd0, 4'hF, k, ik);
        wr(32'h04, 32'hFFFF_FFFF, 4'hF, k, ik);
        wr(32'h00, 32'hFFFF_FFFE, 4'hF, k, ik);
        rd_chk("frozen_a", 32'h00, r, k);
        chk("frozen_a_val", r, 32'hFFFF_FFFE);
        wr(32'h14, 32'd1, 4'hF, k, ik);
        wr(32'h14, 32'd0, 4'hF, k, ik);
        rd_chk("wrap_hi", 32'h04, r, k);
        chk("wrap_hi_zero", r, 32'd0);
        rd_chk("wrap_lo", 32'h00, r, k);
        chk("wrap_lo_zero", r, 32'd0);
        wr(32'h14, 32'd1, 4'hF, k, ik);

        // interrupt rises one cycle after mtime reaches mtimecmp
        wr(32'h08, 32'd100, 4'hF, k, ik);
        wr(32'h0C, 32'd0, 4'hF, k, ik);
        wr(32'h04, 32'd0, 4'hF, k, ik);
        wr(32'h00, 32'd0, 4'hF, km, ik);
        n100 = -1;
        for (int n = km; (n < km + 2000) && (n100 < 0); n++) begin
            if (pred(n) >= 64'd100) n100 = n;
        end
        rise = -1;
        for (int i = 0; (i < 700) && (rise < 0); i++) begin
            @(posedge clk); #1;
            chk("int_track", tint, exp_int(cycles));
            if (tint === 1'b1) rise = cycles;
        end
        chk("int_rise_edge", rise, n100 + 1);
        wr(32'h0C, 32'd1, 4'hF, k, ik);
        chk("int_high_at_wr", ik, 1);
        chk("int_fall", tint, 0);

        // prescaler
`ifdef WB_TIMER_PRESCALE_EN
        wr(32'h10, 32'd3, 4'hF, kp, ik);
        rd_chk("pre_rd", 32'h10, r, k);
        chk("pre_val", r, 32'd3);
        rd_chk("pre_lo_a", 32'h00, ra, ka);
        repeat (40) @(posedge clk);
        rd_chk("pre_lo_b", 32'h00, rb, kb);
        chk("pre_rate", 32'(rb - ra), 32'(((kb - 1 - kp) / 4) - ((ka - 1 - kp) / 4)));
`else
        wr(32'h10, 32'd3, 4'hF, kp, ik);
        rd_chk("pre_rd", 32'h10, r, k);
        chk("pre_absent", r, 32'd0);
        rd_chk("rate_lo_a", 32'h00, ra, ka);
        repeat (40) @(posedge clk);
        rd_chk("rate_lo_b", 32'h00, rb, kb);
        chk("rate_every_cycle", 32'(rb - ra), 32'(kb - ka));
`endif

        // randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                if (a[4:2] == 3'd4) d = d & 32'h7;
                if (a[4:2] == 3'd5) d[0] = ($urandom_range(0, 3) != 0);
                wr(a, d, s, k, ik);
            end else begin
                rd_chk("rand_rd", a, r, k);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // reset during the ack cycle clears ack at once
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14; sel = 4'hF;
        @(posedge clk); #1;
        chk("pre_rst_ack", ack, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack_drop", ack, 0);
        chk("rst_dat_drop", dat_r, 0);
        chk("rst_int_drop", tint, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // reset while a write is pending discards the write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; dat_w = 32'h1234_5678; sel = 4'hF;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_pending_noack", ack, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        model_reset();
        rd_chk("rst_cmp_lo", 32'h08, r, k);
        chk("rst_cmp_kept", r, 32'hFFFF_FFFF);
        rd_chk("rst_mtime", 32'h00, r, k);
        rd_chk("rst_ctrl", 32'h14, r, k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
